// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control path: opcodes, funct codes, ALU control
// codes, aluop classes and the multi-cycle controller state codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Codes consumed directly by the datapath ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: (aluop, funct) -> alucontrol, shared by the
// single-cycle and multi-cycle controllers.
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [3:0]  alucontrol,
  output logic        illegal_funct
);

  always_comb begin
    alucontrol    = ALU_AND;
    illegal_funct = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   illegal_funct = 1'b1;
        endcase
      end
      default: alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/
// writeback, driving all datapath enables and selects plus the ALU control code.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  aluop_t     aluop;
  logic       pcwrite, branch;
  logic       memwrite_raw, irwrite_raw, regwrite_raw;
  logic       illegal_op, in_execute, valid_state;
  logic       illegal_funct;
  logic [3:0] dec_alucontrol;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;
    illegal_op   = 1'b0;
    in_execute   = 1'b0;
    valid_state  = 1'b1;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = 2'b01;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        in_execute = 1'b1;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: valid_state = 1'b0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop         (aluop),
    .funct         (funct),
    .alucontrol    (dec_alucontrol),
    .illegal_funct (illegal_funct)
  );

  // Reset already forces FETCH selects; only the enables and the flag need masking
  assign pcen       = ~reset & (pcwrite | (branch & zero));
  assign irwrite    = ~reset & irwrite_raw;
  assign memwrite   = ~reset & memwrite_raw;
  assign regwrite   = ~reset & regwrite_raw;
  assign illegal    = ~reset & (illegal_op | (in_execute & illegal_funct));
  assign alucontrol = valid_state ? dec_alucontrol : 4'b0000;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: an instruction-path model checked
// every cycle, plus literal expectations per instruction run.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'b000000;
  logic [5:0] funct = 6'b100000;
  logic       zero = 1'b0;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol, state;
  logic       illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .state      (state)
  );

  typedef struct packed {
    logic       pcwrite, branch, memwrite, irwrite, regwrite;
    logic       iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
  } row_t;

  typedef struct packed {
    logic [3:0] st, alu;
    logic       pcen, ill, regwrite, regdst, memwrite, memtoreg, iord;
    logic [1:0] pcsrc;
  } obs_t;

  row_t tbl [12];
  int   m_state = 0;
  obs_t log_q [$];

  logic [31:0] seq_code;
  logic [7:0]  rw_mask, mw_mask, mtr_mask, iord_mask;

  // Instruction-level model: each opcode walks a fixed list of states from FETCH
  function automatic int model_next(int s, logic [5:0] o);
    int path [$];
    case (o)
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000000: path = '{0, 1, 6, 7};
      6'b000100: path = '{0, 1, 8};
      6'b001000: path = '{0, 1, 9, 10};
      6'b000010: path = '{0, 1, 11};
      default:   path = '{0, 1};
    endcase
    for (int i = 0; i < path.size() - 1; i++)
      if (path[i] == s) return path[i+1];
    return 0;
  endfunction

  function automatic logic [4:0] funct_alu(logic [5:0] f);
    case (f)
      6'b100000: return 5'b0_0010;
      6'b100010: return 5'b0_0110;
      6'b100100: return 5'b0_0000;
      6'b100101: return 5'b0_0001;
      6'b101010: return 5'b0_0111;
      default:   return 5'b1_0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_state <= 0;
    else       m_state <= model_next(m_state, op);
  end

  always @(negedge clk) begin : compare
    row_t       r;
    logic [4:0] fa;
    logic [3:0] ealu;
    logic       op_ok, eill;
    obs_t       o;
    r     = tbl[m_state];
    fa    = funct_alu(funct);
    ealu  = (r.aluop == 2'b00) ? 4'b0010 : (r.aluop == 2'b01) ? 4'b0110 : fa[3:0];
    op_ok = op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    eill  = !reset && ((m_state == 1 && !op_ok) || (m_state == 6 && fa[4]));
    checkOutput("state",      32'(state),      32'(m_state));
    checkOutput("pcen",       32'(pcen),       32'(!reset && (r.pcwrite || (r.branch && zero))));
    checkOutput("irwrite",    32'(irwrite),    32'(!reset && r.irwrite));
    checkOutput("memwrite",   32'(memwrite),   32'(!reset && r.memwrite));
    checkOutput("regwrite",   32'(regwrite),   32'(!reset && r.regwrite));
    checkOutput("iord",       32'(iord),       32'(r.iord));
    checkOutput("memtoreg",   32'(memtoreg),   32'(r.memtoreg));
    checkOutput("regdst",     32'(regdst),     32'(r.regdst));
    checkOutput("alusrca",    32'(alusrca),    32'(r.alusrca));
    checkOutput("alusrcb",    32'(alusrcb),    32'(r.alusrcb));
    checkOutput("pcsrc",      32'(pcsrc),      32'(r.pcsrc));
    checkOutput("alucontrol", 32'(alucontrol), 32'(ealu));
    checkOutput("illegal",    32'(illegal),    32'(eill));
    o = '{st: state, alu: alucontrol, pcen: pcen, ill: illegal, regwrite: regwrite,
          regdst: regdst, memwrite: memwrite, memtoreg: memtoreg, iord: iord, pcsrc: pcsrc};
    log_q.push_back(o);
  end

  // Called just after the edge that entered FETCH; runs n cycles back to FETCH.
  // seq_code packs (state+1) per cycle as hex nibbles so the length is visible.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z, input int n);
    op    = o;
    funct = f;
    zero  = z;
    log_q.delete();
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
    seq_code  = '0;
    rw_mask   = '0;
    mw_mask   = '0;
    mtr_mask  = '0;
    iord_mask = '0;
    for (int i = 0; i < log_q.size(); i++) begin
      seq_code     = (seq_code << 4) | 32'(log_q[i].st + 4'd1);
      rw_mask[i]   = log_q[i].regwrite;
      mw_mask[i]   = log_q[i].memwrite;
      mtr_mask[i]  = log_q[i].memtoreg;
      iord_mask[i] = log_q[i].iord;
    end
    checkOutput("back_to_fetch", 32'(state), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 12; i++) tbl[i] = '0;
    tbl[0].irwrite = 1'b1;  tbl[0].pcwrite = 1'b1;  tbl[0].alusrcb = 2'b01;
    tbl[1].alusrcb = 2'b11;
    tbl[2].alusrca = 1'b1;  tbl[2].alusrcb = 2'b10;
    tbl[3].iord = 1'b1;
    tbl[4].regwrite = 1'b1; tbl[4].memtoreg = 1'b1;
    tbl[5].iord = 1'b1;     tbl[5].memwrite = 1'b1;
    tbl[6].alusrca = 1'b1;  tbl[6].aluop = 2'b10;
    tbl[7].regwrite = 1'b1; tbl[7].regdst = 1'b1;
    tbl[8].alusrca = 1'b1;  tbl[8].aluop = 2'b01; tbl[8].pcsrc = 2'b01; tbl[8].branch = 1'b1;
    tbl[9].alusrca = 1'b1;  tbl[9].alusrcb = 2'b10;
    tbl[10].regwrite = 1'b1;
    tbl[11].pcsrc = 2'b10;  tbl[11].pcwrite = 1'b1;

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_alucontrol", 32'(alucontrol), 32'h2);
    checkOutput("reset_alusrcb", 32'(alusrcb), 32'h1);
    reset = 1'b0;

    // LW with zero high to show zero is ignored outside BRANCH
    applyStimulus(6'b100011, 6'b100000, 1'b1, 5);
    checkOutput("lw_seq", seq_code, 32'h12345);
    checkOutput("lw_regwrite", 32'(rw_mask), 32'b10000);
    checkOutput("lw_memtoreg", 32'(mtr_mask), 32'b10000);
    checkOutput("lw_iord", 32'(iord_mask), 32'b01000);

    applyStimulus(6'b000000, 6'b100010, 1'b0, 4);
    checkOutput("rsub_seq", seq_code, 32'h1278);
    checkOutput("rsub_alu", 32'(log_q[2].alu), 32'b0110);
    checkOutput("rsub_regdst", 32'(log_q[3].regdst), 32'd1);
    checkOutput("rsub_regwrite", 32'(log_q[3].regwrite), 32'd1);
    applyStimulus(6'b000000, 6'b101010, 1'b0, 4);
    checkOutput("rslt_alu", 32'(log_q[2].alu), 32'b0111);
    applyStimulus(6'b000000, 6'b100101, 1'b0, 4);
    checkOutput("ror_alu", 32'(log_q[2].alu), 32'b0001);

    applyStimulus(6'b000100, 6'b100000, 1'b1, 3);
    checkOutput("beq_seq", seq_code, 32'h129);
    checkOutput("beq_taken_pcen", 32'(log_q[2].pcen), 32'd1);
    checkOutput("beq_pcsrc", 32'(log_q[2].pcsrc), 32'b01);
    checkOutput("beq_alu", 32'(log_q[2].alu), 32'b0110);
    applyStimulus(6'b000100, 6'b100000, 1'b0, 3);
    checkOutput("beq_nottaken_pcen", 32'(log_q[2].pcen), 32'd0);

    applyStimulus(6'b101011, 6'b100000, 1'b0, 4);
    checkOutput("sw_seq", seq_code, 32'h1236);
    checkOutput("sw_memwrite", 32'(mw_mask), 32'b1000);

    applyStimulus(6'b000010, 6'b100000, 1'b0, 3);
    checkOutput("j_seq", seq_code, 32'h12C);
    checkOutput("j_pcsrc", 32'(log_q[2].pcsrc), 32'b10);
    checkOutput("j_pcen", 32'(log_q[2].pcen), 32'd1);

    applyStimulus(6'b001000, 6'b100000, 1'b0, 4);
    checkOutput("addi_seq", seq_code, 32'h12AB);
    checkOutput("addi_regwrite", 32'(rw_mask), 32'b1000);

    applyStimulus(6'b111111, 6'b100000, 1'b0, 2);
    checkOutput("illop_seq", seq_code, 32'h12);
    checkOutput("illop_flag", 32'(log_q[1].ill), 32'd1);
    checkOutput("illop_writes", 32'(rw_mask | mw_mask), 32'd0);

    applyStimulus(6'b000000, 6'b000000, 1'b0, 4);
    checkOutput("illfunct_seq", seq_code, 32'h1278);
    checkOutput("illfunct_alu", 32'(log_q[2].alu), 32'b0000);
    checkOutput("illfunct_flag", 32'(log_q[2].ill), 32'd1);

    // Abort an LW in MEMRD with an asynchronous mid-cycle reset
    op    = 6'b100011;
    funct = 6'b100000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_reset_state", 32'(state), 32'd3);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_state", 32'(state), 32'd0);
    checkOutput("reset_enables", 32'({pcen, irwrite, memwrite, regwrite, illegal}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("release_irwrite", 32'(irwrite), 32'd1);
    checkOutput("release_pcen", 32'(pcen), 32'd1);
    #1;
    applyStimulus(6'b100011, 6'b100000, 1'b0, 5);
    checkOutput("lw_after_reset_seq", seq_code, 32'h12345);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle MIPS control unit. It sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath enable and mux select, and it generates the 4-bit `alucontrol` code consumed by the datapath ALU. This block is the producer side of the ALU control interface. It replaces the single-cycle main decoder when the shared-memory multi-cycle datapath is built.

## Interface
Parameters:
- none; all encodings are fixed in the shared package.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 6: `instr[31:26]` taken from the instruction register.
- `funct` in 6: `instr[5:0]` taken from the instruction register.
- `zero` in 1: ALU Zero flag.
- `pcen` out 1: PC write enable, equal to `pcwrite | (branch & zero)`.
- `memwrite` out 1: memory write enable.
- `irwrite` out 1: instruction register write enable.
- `regwrite` out 1: register file write enable.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `memtoreg` out 1: writeback data select. 0 = ALUOut, 1 = Data register.
- `regdst` out 1: destination register select. 0 = rt, 1 = rd.
- `alusrca` out 1: ALU A select. 0 = PC, 1 = A register.
- `alusrcb` out 2: ALU B select. 00 = B register, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` out 2: next-PC select. 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alucontrol` out 4: ALU operation code.
  - 0000 = AND
  - 0001 = OR
  - 0010 = ADD
  - 0110 = SUB
  - 0111 = SLT
- `illegal` out 1: unsupported op or funct detected.
- `state` out 4: current state, for debug.

## Operation
- Supported opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- Supported funct codes: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
- Moore FSM with a 4-bit state register. Outputs decode from state only, except `pcen`, which also uses `zero`.
- Every output not listed for a state is 0 in that state. `aluop` defaults to 00.
- States and their outputs:
  - FETCH(0): irwrite=1, pcwrite=1, alusrcb=01, aluop=00. Next state: DECODE.
  - DECODE(1): alusrcb=11, aluop=00. Next state depends on op:
    - LW or SW: MEMADR.
    - RTYPE: EXECUTE.
    - BEQ: BRANCH.
    - ADDI: ADDIEX.
    - J: JUMP.
    - Any other op: FETCH, with `illegal`=1 for this cycle.
  - MEMADR(2): alusrca=1, alusrcb=10. Next state: MEMRD if LW, MEMWR if SW.
  - MEMRD(3): iord=1. Next state: MEMWB.
  - MEMWB(4): regwrite=1, memtoreg=1. Next state: FETCH.
  - MEMWR(5): iord=1, memwrite=1. Next state: FETCH.
  - EXECUTE(6): alusrca=1, alusrcb=00, aluop=10. Next state: ALUWB.
  - ALUWB(7): regwrite=1, regdst=1. Next state: FETCH.
  - BRANCH(8): alusrca=1, aluop=01, pcsrc=01, branch=1. Next state: FETCH.
  - ADDIEX(9): alusrca=1, alusrcb=10. Next state: ADDIWB.
  - ADDIWB(10): regwrite=1. Next state: FETCH.
  - JUMP(11): pcsrc=10, pcwrite=1. Next state: FETCH.
- State codes 12–15 are unreachable. If the register ever holds one, the next state is FETCH and all outputs are 0.
- ALU decoder mapping:
  - aluop 00 → 0010 (ADD).
  - aluop 01 → 0110 (SUB).
  - aluop 10 → from funct: ADD→0010, SUB→0110, AND→0000, OR→0001, SLT→0111.
  - aluop 10 with an unknown funct → 0000, and `illegal`=1 in EXECUTE. The FSM still proceeds to ALUWB.

## Timing
- Reset:
  - On assertion, `state` goes to FETCH immediately.
  - While `reset`=1, `pcen`, `irwrite`, `memwrite`, `regwrite` and `illegal` are forced to 0.
  - The remaining outputs take their FETCH values: alusrcb=01, alucontrol=0010, all other selects 0.
- The first FETCH cycle with enables active is the first cycle after `reset` deasserts.
- Reset mid-instruction aborts the instruction. No write enable pulses after assertion.
- Cycles from FETCH to the next FETCH:
  - LW: 5
  - SW: 4
  - RTYPE: 4
  - ADDI: 4
  - BEQ: 3
  - J: 3
  - Illegal op: 2
- `zero` matters only in BRANCH, where `pcen` = `zero`. In every other state `zero` is ignored.
- `op` and `funct` are sampled combinationally each cycle. The IR holds them stable because `irwrite` is asserted only in FETCH.

## Structure
- Package `mips_pkg` holds:
  - opcode and funct localparams;
  - the `alucontrol` encodings, shared with the ALU;
  - the `aluop` encodings;
  - the state enum/localparams.
- Sub-module `alu_decoder`: purely combinational, (aluop, funct) → (alucontrol, illegal_funct). It is also reused by the single-cycle controller.
- Top level contains the state register, next-state logic, output decode and `pcen` gating.

## Test plan
- Reset handling:
  - Stimulus: assert `reset` mid-MEMRD, hold 2 cycles, release.
  - Required: `state`=0 immediately on assertion; all enables 0 during reset; `irwrite`=`pcen`=1 in the first cycle after release.
- LW sequence:
  - Stimulus: op=100011.
  - Required: state sequence 0,1,2,3,4,0.
  - Required: `memtoreg`=`regwrite`=1 only in state 4, and `iord`=1 in state 3.
- R-type decode:
  - Stimulus: op=000000 with funct=100010, then 101010, then 100101.
  - Required: `alucontrol` in EXECUTE is 0110, 0111 and 0001 respectively.
  - Required: ALUWB has `regdst`=1 and `regwrite`=1.
- BEQ:
  - Stimulus: op=000100 with `zero`=1, then repeat with `zero`=0.
  - Required: in BRANCH, `pcen`=1 with `pcsrc`=01 and `alucontrol`=0110 for the first run; `pcen`=0 for the second.
- SW and J:
  - Stimulus: op=101011, then op=000010.
  - Required for SW: state sequence 0,1,2,5,0, with `memwrite`=1 only in state 5.
  - Required for J: state sequence 0,1,11,0, with `pcsrc`=10 and `pcen`=1 in state 11.
- Illegal cases:
  - Stimulus: op=111111.
  - Required: `illegal`=1 in DECODE, then FETCH; no write enables asserted.
  - Stimulus: RTYPE with funct=000000.
  - Required: `alucontrol`=0000 and `illegal`=1 in EXECUTE.
